// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampling tick divider and
// start/data/stop FSM that captures LSB-first frames.
// Ports:
//   clk_wz          system clock, rising edge
//   i_reset         synchronous active-high reset
//   i_rx_data       asynchronous serial line, idle high
//   i_rx_clear      consumer acknowledge, clears ready/frame_err
//   o_rx_data       last correctly framed byte
//   o_rx_ready      unconsumed byte present
//   o_rx_done       one-cycle pulse per good frame
//   o_rx_frame_err  sticky: last frame had a low stop bit
module uart_rx #(
   parameter int CLK_FR      = 50000000,
   parameter int BAUD_RATE   = 9600,
   parameter int RX_DIV_SAMP = 16,
   parameter int DBIT        = 8,
   parameter int SB_TICK     = 16
) (
   input  logic            clk_wz,
   input  logic            i_reset,
   input  logic            i_rx_data,
   input  logic            i_rx_clear,
   output logic [DBIT-1:0] o_rx_data,
   output logic            o_rx_ready,
   output logic            o_rx_done,
   output logic            o_rx_frame_err
);

   localparam int DIV = CLK_FR / (BAUD_RATE * RX_DIV_SAMP);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int NW  = (DBIT > 1) ? $clog2(DBIT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [1:0]      sync_q;
   logic [3:0]      s_cnt_q, s_cnt_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic [DBIT-1:0] data_q, data_d;
   logic            ready_q, ready_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;
   logic            tick;
   logic            rx_s;

   assign rx_s   = sync_q[1];
   assign tick   = (tcnt_q == TW'(DIV - 1));
   assign tcnt_d = tick ? '0 : tcnt_q + TW'(1);

   always_comb begin
      state_d = state_q;
      s_cnt_d = s_cnt_q;
      n_d     = n_q;
      b_d     = b_q;
      data_d  = data_q;
      done_d  = 1'b0;
      // Frame completion below overrides a same-cycle clear.
      ready_d = ready_q & ~i_rx_clear;
      ferr_d  = ferr_q & ~i_rx_clear;
      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               s_cnt_d = '0;
            end
         end
         START: begin
            if (tick) begin
               if (s_cnt_q == 4'd7) begin
                  s_cnt_d = '0;
                  n_d     = '0;
                  // Mid-start re-check rejects glitches.
                  state_d = rx_s ? IDLE : DATA;
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_cnt_q == 4'd15) begin
                  s_cnt_d = '0;
                  b_d     = {rx_s, b_q[DBIT-1:1]};
                  if (n_q == NW'(DBIT - 1)) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s_cnt_q == 4'(SB_TICK - 1)) begin
                  state_d = IDLE;
                  s_cnt_d = '0;
                  if (rx_s) begin
                     data_d  = b_q;
                     done_d  = 1'b1;
                     ready_d = 1'b1;
                     ferr_d  = 1'b0;
                  end else begin
                     ferr_d  = 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_wz) begin
      if (i_reset) begin
         state_q <= IDLE;
         tcnt_q  <= '0;
         sync_q  <= 2'b11;
         s_cnt_q <= '0;
         n_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         sync_q  <= {sync_q[0], i_rx_data};
         s_cnt_q <= s_cnt_d;
         n_q     <= n_d;
         b_q     <= b_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   assign o_rx_data      = data_q;
   assign o_rx_ready     = ready_q;
   assign o_rx_done      = done_q;
   assign o_rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected bytes,
// a negedge monitor pops and compares on every o_rx_done pulse.
module tb_uart_rx;

   localparam int CLK_FR = 1600000;
   localparam int BAUD   = 10000;
   localparam int SAMP   = 16;
   // DIV = 10 clocks per tick, 160 clocks per bit
   localparam int BIT    = 160;

   logic       clk_wz = 1'b0;
   logic       i_reset;
   logic       i_rx_data;
   logic       i_rx_clear;
   logic [7:0] o_rx_data;
   logic       o_rx_ready;
   logic       o_rx_done;
   logic       o_rx_frame_err;

   int         n_chk  = 0;
   int         n_fail = 0;
   int         n_done = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;
   logic       done_prev = 1'b0;

   always #5 clk_wz = ~clk_wz;

   uart_rx #(
      .CLK_FR     (CLK_FR),
      .BAUD_RATE  (BAUD),
      .RX_DIV_SAMP(SAMP),
      .DBIT       (8),
      .SB_TICK    (16)
   ) dut (
      .clk_wz        (clk_wz),
      .i_reset       (i_reset),
      .i_rx_data     (i_rx_data),
      .i_rx_clear    (i_rx_clear),
      .o_rx_data     (o_rx_data),
      .o_rx_ready    (o_rx_ready),
      .o_rx_done     (o_rx_done),
      .o_rx_frame_err(o_rx_frame_err)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk_wz) begin
      if (o_rx_done) begin
         n_done++;
         chk("done_one_cycle", {31'd0, done_prev}, 32'd0);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got data %0h expected no pulse",
                     o_rx_data);
         end else begin
            exp_b = exp_q.pop_front();
            chk("rx_data", {24'd0, o_rx_data}, {24'd0, exp_b});
            chk("ready_on_done", {31'd0, o_rx_ready}, 32'd1);
            chk("ferr_on_done", {31'd0, o_rx_frame_err}, 32'd0);
         end
      end
      done_prev = o_rx_done;
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk_wz);
      #1;
   endtask

   task automatic send_bit(input logic v);
      i_rx_data = v;
      clks(BIT);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      if (stop_ok) exp_q.push_back(b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      if (stop_ok) begin
         send_bit(1'b1);
      end else begin
         // Low through the mid-stop sample, high before the
         // re-check of the spurious start that follows.
         i_rx_data = 1'b0;
         clks(BIT * 3 / 4);
         i_rx_data = 1'b1;
         clks(2 * BIT);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [7:0] d,
                           input logic r, input logic f);
      chk({tag, "_data"}, {24'd0, o_rx_data}, {24'd0, d});
      chk({tag, "_ready"}, {31'd0, o_rx_ready}, {31'd0, r});
      chk({tag, "_ferr"}, {31'd0, o_rx_frame_err}, {31'd0, f});
      chk({tag, "_done"}, {31'd0, o_rx_done}, 32'd0);
   endtask

   initial begin
      i_reset    = 1'b1;
      i_rx_data  = 1'b1;
      i_rx_clear = 1'b0;
      clks(4);
      chk_outs("reset", 8'h00, 1'b0, 1'b0);
      i_reset = 1'b0;
      clks(BIT);

      send_byte(8'h64, 1'b1);
      clks(BIT);
      chk_outs("byte64", 8'h64, 1'b1, 1'b0);

      i_rx_clear = 1'b1;
      clks(1);
      i_rx_clear = 1'b0;
      chk_outs("clear1", 8'h64, 1'b0, 1'b0);

      send_byte(8'h00, 1'b1);
      send_byte(8'h23, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h20, 1'b1);
      clks(BIT);
      chk_outs("burst", 8'h20, 1'b1, 1'b0);
      chk("burst_done_cnt", n_done, 32'd5);

      i_rx_data = 1'b0;
      clks(30);
      i_rx_data = 1'b1;
      clks(3 * BIT);
      chk_outs("glitch", 8'h20, 1'b1, 1'b0);
      chk("glitch_done_cnt", n_done, 32'd5);

      send_byte(8'hFF, 1'b0);
      clks(BIT);
      chk_outs("frame_err", 8'h20, 1'b1, 1'b1);
      chk("ferr_done_cnt", n_done, 32'd5);

      i_rx_clear = 1'b1;
      clks(1);
      i_rx_clear = 1'b0;
      chk_outs("clear2", 8'h20, 1'b0, 1'b0);

      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      i_rx_data = 1'b1;
      i_reset   = 1'b1;
      clks(4);
      chk_outs("mid_reset", 8'h00, 1'b0, 1'b0);
      i_reset = 1'b0;
      clks(2 * BIT);
      chk("abort_done_cnt", n_done, 32'd5);

      send_byte(8'h63, 1'b1);
      clks(BIT);
      chk_outs("byte63", 8'h63, 1'b1, 1'b0);
      chk("final_done_cnt", n_done, 32'd6);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
